booth_multiplier: RTL and testbench

Multi-cycle signed radix-2 Booth multiplier for the processor's execute stage, sitting alongside the ALU. It consumes the same add/subtract datapath as the CLA adder tree: one add-or-subtract of the multiplicand into a partial-product accumulator per cycle, then an arithmetic right shift. It returns the low WIDTH bits of the product with an overflow exception flag, and signals completion with a one-cycle ready pulse.

---
 rtl/booth_multiplier.sv | 79 +++++++
 tb/tb_booth_multiplier.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/booth_multiplier.sv
// booth_multiplier: multi-cycle signed radix-2 Booth multiplier, low WIDTH bits plus overflow flag.
module booth_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             result_rdy,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, next_state;
    logic [WIDTH:0]   m, acc, sum, acc_n;
    logic [WIDTH-1:0] q, q_n;
    logic             q_1;
    logic [CW-1:0]    cnt;
    logic [1:0]       booth;
    logic [WIDTH:0]   prod_hi;
    logic             accept, last, ovf;

    always_ff @(posedge clock)
        state <= !reset_n ? IDLE : next_state;

    always_comb begin
        accept     = state == IDLE && start;
        last       = state == RUN && cnt == CW'(WIDTH - 1);
        next_state = accept ? RUN : last ? IDLE : state;
    end

    // One Booth step: conditional add/subtract, then arithmetic shift of {acc, q, q_1}.
    always_comb begin
        booth   = {q[0], q_1};
        sum     = booth == 2'b01 ? acc + m : booth == 2'b10 ? acc - m : acc;
        acc_n   = {sum[WIDTH], sum[WIDTH:1]};
        q_n     = {sum[0], q[WIDTH-1:1]};
        prod_hi = {acc_n[WIDTH-1:0], q_n[WIDTH-1]};
        ovf     = !(&prod_hi || ~|prod_hi);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            m          <= '0;
            acc        <= '0;
            q          <= '0;
            q_1        <= 1'b0;
            cnt        <= '0;
            result     <= '0;
            exception  <= 1'b0;
            result_rdy <= 1'b0;
        end else begin
            result_rdy <= last;
            if (accept) begin
                m   <= {operand_a[WIDTH-1], operand_a};
                acc <= '0;
                q   <= operand_b;
                q_1 <= 1'b0;
                cnt <= '0;
            end else if (state == RUN) begin
                acc <= acc_n;
                q   <= q_n;
                q_1 <= q[0];
                cnt <= cnt + CW'(1);
            end
            if (last) begin
                result    <= q_n;
                exception <= ovf;
            end
        end
    end

    assign busy = state == RUN;
endmodule

// File: tb/tb_booth_multiplier.sv
// tb_booth_multiplier: table-driven vectors plus directed multi-cycle sequences for booth_multiplier.
module tb_booth_multiplier;
    logic        clock = 0;
    logic        reset_n = 0;
    logic        start = 0;
    logic [31:0] operand_a = 0;
    logic [31:0] operand_b = 0;
    logic [31:0] result;
    logic        exception;
    logic        result_rdy;
    logic        busy;

    int errors = 0;
    int checks = 0;

    booth_multiplier #(.WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .operand_a(operand_a), .operand_b(operand_b),
        .result(result), .exception(exception),
        .result_rdy(result_rdy), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        e;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Counts sampled cycles (at negedge) until result_rdy; lat = -1 on timeout.
    task automatic wait_rdy(output int lat, output int bcnt);
        bcnt = 0;
        lat  = -1;
        for (int i = 1; i <= 100; i++) begin
            if (result_rdy) begin
                lat = i;
                break;
            end
            if (busy) bcnt++;
            @(negedge clock);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        start     = 1;
        operand_a = a;
        operand_b = b;
        @(negedge clock);
        start     = 0;
        operand_a = 32'hDEAD_BEEF;
        operand_b = 32'hDEAD_BEEF;
    endtask

    task automatic count_pulses(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (result_rdy) pulses++;
        end
    endtask

    vec_t vecs[12];
    int   lat, bcnt, pulses;

    initial begin
        vecs[0]  = '{32'd3,        32'd5,        32'h0000_000F, 1'b0};
        vecs[1]  = '{-32'sd7,      32'd6,        32'hFFFF_FFD6, 1'b0};
        vecs[2]  = '{-32'sd7,      -32'sd6,      32'h0000_002A, 1'b0};
        vecs[3]  = '{32'd0,        32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[4]  = '{32'h8000_0000, 32'd1,        32'h8000_0000, 1'b0};
        vecs[5]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[6]  = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
        vecs[7]  = '{32'h7FFF_FFFF, 32'd2,        32'hFFFF_FFFE, 1'b1};
        vecs[8]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1};
        vecs[9]  = '{32'd46341,    32'd46341,    32'h8000_1219, 1'b1};
        vecs[10] = '{32'd46340,    32'd46340,    32'h7FFE_A810, 1'b0};
        vecs[11] = '{32'hFFFF_0000, 32'h0000_8000, 32'h8000_0000, 1'b0};

        repeat (2) @(negedge clock);
        check("reset_result", result, 0);
        check("reset_exception", 32'(exception), 0);
        check("reset_rdy", 32'(result_rdy), 0);
        check("reset_busy", 32'(busy), 0);
        reset_n = 1;
        @(negedge clock);

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].a, vecs[i].b);
            wait_rdy(lat, bcnt);
            check($sformatf("v%0d_latency", i), 32'(lat), 33);
            check($sformatf("v%0d_result", i), result, vecs[i].r);
            check($sformatf("v%0d_exception", i), 32'(exception), 32'(vecs[i].e));
            if (i == 0) begin
                check("basic_busy_cycles", 32'(bcnt), 32);
                check("basic_busy_at_rdy", 32'(busy), 0);
                @(negedge clock);
                check("basic_rdy_one_cycle", 32'(result_rdy), 0);
                check("basic_result_held", result, 32'h0000_000F);
            end
            @(negedge clock);
        end

        // Start while busy must be ignored.
        issue(32'd4, 32'd4);
        repeat (9) @(negedge clock);
        start     = 1;
        operand_a = 32'd9;
        operand_b = 32'd9;
        @(negedge clock);
        start = 0;
        wait_rdy(lat, bcnt);
        check("busyprot_latency", 32'(lat), 23);
        check("busyprot_result", result, 32'd16);
        check("busyprot_busy_at_rdy", 32'(busy), 0);
        count_pulses(40, pulses);
        check("busyprot_no_second_rdy", 32'(pulses), 0);
        check("busyprot_idle", 32'(busy), 0);

        // Back-to-back: second start issued in the result_rdy cycle.
        issue(32'd6, 32'd7);
        wait_rdy(lat, bcnt);
        check("b2b_first_result", result, 32'd42);
        issue(32'd2, -32'sd3);
        check("b2b_busy_after_accept", 32'(busy), 1);
        check("b2b_rdy_dropped", 32'(result_rdy), 0);
        repeat (20) @(negedge clock);
        check("b2b_result_held", result, 32'd42);
        wait_rdy(lat, bcnt);
        check("b2b_spacing", 32'(lat + 20), 33);
        check("b2b_second_result", result, 32'hFFFF_FFFA);
        check("b2b_second_exception", 32'(exception), 0);
        @(negedge clock);

        // Reset mid-operation; a start coinciding with reset is ignored.
        issue(32'd5, 32'd5);
        repeat (13) @(negedge clock);
        reset_n   = 0;
        start     = 1;
        operand_a = 32'd3;
        operand_b = 32'd3;
        @(negedge clock);
        reset_n = 1;
        start   = 0;
        check("midreset_busy", 32'(busy), 0);
        check("midreset_result", result, 0);
        check("midreset_exception", 32'(exception), 0);
        check("midreset_rdy", 32'(result_rdy), 0);
        count_pulses(40, pulses);
        check("midreset_no_rdy", 32'(pulses), 0);
        check("midreset_still_idle", 32'(busy), 0);
        issue(32'd5, 32'd5);
        wait_rdy(lat, bcnt);
        check("postreset_latency", 32'(lat), 33);
        check("postreset_result", result, 32'd25);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
